// File: rtl/l1_trig_sequencer.sv
// LV1/ECR front-end for the L1 trigger-ID counter: queues LV1 commands and
// expands each into a burst of TrigCount pulses; ECR aborts, flushes and clears.
module l1_trig_sequencer #(
  parameter int MAX_PEND = 4,
  parameter int PEND_W   = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Lv1Cmd,
  input  logic              EcrCmd,
  input  logic [3:0]        TrigCount,
  input  logic              ClrOverflow,
  output logic              TrigOut,
  output logic              ClearTrigId,
  output logic [3:0]        BurstIdx,
  output logic [PEND_W-1:0] PendCnt,
  output logic              Busy,
  output logic              Overflow,
  output logic [1:0]        FsmState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PEND);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [3:0]        last_idx;
  logic [3:0]        last_idx_n;
  logic [3:0]        idx_n;
  logic [PEND_W-1:0] pend_n;
  logic              ecr_eff;
  logic              last_pulse;
  logic              start;
  logic              accept;
  logic              full;
  logic              inc;
  logic              drop;

  assign FsmState = state;

  // An ECR arriving while a clear is already in progress merges into it.
  assign ecr_eff    = EcrCmd && (state != CLEAR);
  assign last_pulse = (BurstIdx == last_idx);
  assign accept     = Lv1Cmd && !ecr_eff;
  assign full       = (PendCnt == MAX_P);

  always_comb begin
    state_n = state;
    start   = 1'b0;
    idx_n   = 4'd0;
    case (state)
      IDLE: begin
        if (ecr_eff) begin
          state_n = CLEAR;
        end else if (PendCnt != '0) begin
          state_n = BURST;
          start   = 1'b1;
        end
      end
      BURST: begin
        if (ecr_eff) begin
          state_n = CLEAR;
        end else if (last_pulse) begin
          // Back-to-back bursts: stay in BURST and restart the index.
          if (PendCnt != '0) start = 1'b1;
          else               state_n = IDLE;
        end else begin
          idx_n = BurstIdx + 4'd1;
        end
      end
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A full queue still accepts an LV1 when a burst start frees a slot.
  assign inc  = accept && ((PendCnt < MAX_P) || (full && start));
  assign drop = accept && full && !start;

  always_comb begin
    pend_n = PendCnt;
    if (ecr_eff)            pend_n = '0;
    else if (inc && !start) pend_n = PendCnt + 1'b1;
    else if (start && !inc) pend_n = PendCnt - 1'b1;
  end

  // Burst length is stored as its last index; TrigCount=0 wraps to 15 (16 pulses).
  assign last_idx_n = start ? (TrigCount - 4'd1) : last_idx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      TrigOut     <= 1'b0;
      ClearTrigId <= 1'b0;
      BurstIdx    <= 4'd0;
      PendCnt     <= '0;
      Busy        <= 1'b0;
      Overflow    <= 1'b0;
      last_idx    <= 4'hF;
    end else begin
      state       <= state_n;
      TrigOut     <= (state_n == BURST);
      ClearTrigId <= (state_n == CLEAR);
      BurstIdx    <= idx_n;
      PendCnt     <= pend_n;
      Busy        <= (state_n != IDLE) || (pend_n != '0);
      last_idx    <= last_idx_n;
      if (drop)             Overflow <= 1'b1;
      else if (ClrOverflow) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l1_trig_sequencer.sv
// Directed bench for l1_trig_sequencer: latency, burst lengths, queueing,
// overflow, ECR abort/clear and asynchronous reset.
module tb_l1_trig_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Lv1Cmd = 1'b0;
  logic       EcrCmd = 1'b0;
  logic [3:0] TrigCount = 4'd1;
  logic       ClrOverflow = 1'b0;
  logic       TrigOut;
  logic       ClearTrigId;
  logic [3:0] BurstIdx;
  logic [2:0] PendCnt;
  logic       Busy;
  logic       Overflow;
  logic [1:0] FsmState;

  int compared = 0;
  int mismatched = 0;

  // Expected trace for three back-to-back LV1s with TrigCount=3.
  logic [2:0] exp_pend [11] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [3:0] exp_idx  [11] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
  logic       exp_trig [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 Clk = ~Clk;

  l1_trig_sequencer #(.MAX_PEND(4), .PEND_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Lv1Cmd(Lv1Cmd), .EcrCmd(EcrCmd),
    .TrigCount(TrigCount), .ClrOverflow(ClrOverflow), .TrigOut(TrigOut),
    .ClearTrigId(ClearTrigId), .BurstIdx(BurstIdx), .PendCnt(PendCnt),
    .Busy(Busy), .Overflow(Overflow), .FsmState(FsmState)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) tick();
    compared++;
    if ({TrigOut, ClearTrigId, BurstIdx, PendCnt, Busy, Overflow, FsmState} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_state: got trig=%b clr=%b idx=%0d pend=%0d busy=%b ovf=%b st=%0d, want all 0",
               TrigOut, ClearTrigId, BurstIdx, PendCnt, Busy, Overflow, FsmState);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single_pulse();
    int pulses = 0;
    TrigCount = 4'd1;
    Lv1Cmd = 1'b1;
    tick();
    Lv1Cmd = 1'b0;
    compared++;
    if (PendCnt !== 3'd1 || TrigOut !== 1'b0 || Busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_queued: got pend=%0d trig=%b busy=%b, want 1/0/1", PendCnt, TrigOut, Busy);
    end
    tick();
    compared++;
    if (TrigOut !== 1'b1 || BurstIdx !== 4'd0 || PendCnt !== 3'd0) begin
      mismatched++;
      $display("FAIL single_pulse: got trig=%b idx=%0d pend=%0d, want 1/0/0", TrigOut, BurstIdx, PendCnt);
    end
    tick();
    compared++;
    if (TrigOut !== 1'b0 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_end: got trig=%b busy=%b, want 0/0", TrigOut, Busy);
    end
    repeat (5) begin
      tick();
      if (TrigOut === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL single_quiet: got %0d extra pulses, want 0", pulses);
    end
  endtask

  task automatic test_burst16();
    TrigCount = 4'd0;
    Lv1Cmd = 1'b1;
    tick();
    Lv1Cmd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      // A change mid-burst must not shorten the burst in flight.
      if (i == 0) TrigCount = 4'd2;
      compared++;
      if (TrigOut !== 1'b1 || BurstIdx !== 4'(i)) begin
        mismatched++;
        $display("FAIL burst16_step%0d: got trig=%b idx=%0d, want 1/%0d", i, TrigOut, BurstIdx, i);
      end
    end
    tick();
    compared++;
    if (TrigOut !== 1'b0 || Busy !== 1'b0 || BurstIdx !== 4'd0) begin
      mismatched++;
      $display("FAIL burst16_end: got trig=%b busy=%b idx=%0d, want 0/0/0", TrigOut, Busy, BurstIdx);
    end
  endtask

  task automatic test_back_to_back();
    TrigCount = 4'd3;
    for (int i = 0; i < 11; i++) begin
      Lv1Cmd = (i < 3);
      tick();
      compared++;
      if (PendCnt !== exp_pend[i] || BurstIdx !== exp_idx[i] || TrigOut !== exp_trig[i]) begin
        mismatched++;
        $display("FAIL b2b_cycle%0d: got pend=%0d idx=%0d trig=%b, want %0d/%0d/%b",
                 i, PendCnt, BurstIdx, TrigOut, exp_pend[i], exp_idx[i], exp_trig[i]);
      end
    end
    Lv1Cmd = 1'b0;
  endtask

  task automatic test_overflow();
    int pulses = 0;
    int budget = 0;
    TrigCount = 4'd8;
    for (int i = 0; i < 6; i++) begin
      Lv1Cmd = 1'b1;
      // ClrOverflow together with the dropping LV1: the set must win.
      ClrOverflow = (i == 5);
      tick();
      if (TrigOut === 1'b1) pulses++;
      if (i == 4) begin
        compared++;
        if (PendCnt !== 3'd4 || Overflow !== 1'b0) begin
          mismatched++;
          $display("FAIL ovf_fill: got pend=%0d ovf=%b, want 4/0", PendCnt, Overflow);
        end
      end
    end
    Lv1Cmd = 1'b0;
    ClrOverflow = 1'b0;
    compared++;
    if (PendCnt !== 3'd4 || Overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_drop: got pend=%0d ovf=%b, want 4/1", PendCnt, Overflow);
    end
    while (Busy === 1'b1 && budget < 100) begin
      tick();
      if (TrigOut === 1'b1) pulses++;
      budget++;
    end
    compared++;
    if (pulses != 40 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_total: got %0d pulses busy=%b, want 40/0", pulses, Busy);
    end
    compared++;
    if (Overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_sticky: got ovf=%b, want 1", Overflow);
    end
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    compared++;
    if (Overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", Overflow);
    end
  endtask

  task automatic test_ecr_abort();
    int pulses = 0;
    TrigCount = 4'd8;
    Lv1Cmd = 1'b1;
    repeat (3) tick();
    Lv1Cmd = 1'b0;
    repeat (2) tick();
    compared++;
    if (BurstIdx !== 4'd3 || PendCnt !== 3'd2 || TrigOut !== 1'b1) begin
      mismatched++;
      $display("FAIL ecr_setup: got idx=%0d pend=%0d trig=%b, want 3/2/1", BurstIdx, PendCnt, TrigOut);
    end
    EcrCmd = 1'b1;
    tick();
    EcrCmd = 1'b0;
    compared++;
    if (TrigOut !== 1'b0 || ClearTrigId !== 1'b1 || PendCnt !== 3'd0 || BurstIdx !== 4'd0 || Busy !== 1'b1) begin
      mismatched++;
      $display("FAIL ecr_clear: got trig=%b clr=%b pend=%0d idx=%0d busy=%b, want 0/1/0/0/1",
               TrigOut, ClearTrigId, PendCnt, BurstIdx, Busy);
    end
    tick();
    compared++;
    if (ClearTrigId !== 1'b0 || Busy !== 1'b0 || FsmState !== 2'd0) begin
      mismatched++;
      $display("FAIL ecr_idle: got clr=%b busy=%b st=%0d, want 0/0/0", ClearTrigId, Busy, FsmState);
    end
    repeat (10) begin
      tick();
      if (TrigOut === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL ecr_quiet: got %0d pulses after abort, want 0", pulses);
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    TrigCount = 4'd0;
    Lv1Cmd = 1'b1;
    tick();
    Lv1Cmd = 1'b0;
    repeat (3) tick();
    #1;
    Reset = 1'b0;
    #1;
    compared++;
    if ({TrigOut, ClearTrigId, BurstIdx, PendCnt, Busy, Overflow} !== 11'd0) begin
      mismatched++;
      $display("FAIL async_reset: got trig=%b idx=%0d pend=%0d busy=%b, want all 0",
               TrigOut, BurstIdx, PendCnt, Busy);
    end
    #4;
    Reset = 1'b1;
    repeat (20) begin
      tick();
      if (TrigOut === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_quiet: got %0d pulses busy=%b, want 0/0", pulses, Busy);
    end
  endtask

  task automatic test_lv1_ecr_same_cycle();
    TrigCount = 4'd8;
    Lv1Cmd = 1'b1;
    repeat (6) tick();
    compared++;
    if (Overflow !== 1'b1 || PendCnt !== 3'd4) begin
      mismatched++;
      $display("FAIL same_setup: got ovf=%b pend=%0d, want 1/4", Overflow, PendCnt);
    end
    // Full queue, LV1 with ECR: LV1 discarded silently, overflow kept.
    EcrCmd = 1'b1;
    tick();
    compared++;
    if (ClearTrigId !== 1'b1 || TrigOut !== 1'b0 || PendCnt !== 3'd0 || Overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL same_full: got clr=%b trig=%b pend=%0d ovf=%b, want 1/0/0/1",
               ClearTrigId, TrigOut, PendCnt, Overflow);
    end
    Lv1Cmd = 1'b0;
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    compared++;
    if (ClearTrigId !== 1'b0 || Overflow !== 1'b0 || FsmState !== 2'd0) begin
      mismatched++;
      $display("FAIL same_after: got clr=%b ovf=%b st=%0d, want 0/0/0", ClearTrigId, Overflow, FsmState);
    end
    Lv1Cmd = 1'b1;
    tick();
    Lv1Cmd = 1'b0;
    compared++;
    if (ClearTrigId !== 1'b1 || PendCnt !== 3'd0 || Overflow !== 1'b0 || TrigOut !== 1'b0) begin
      mismatched++;
      $display("FAIL same_idle: got clr=%b pend=%0d ovf=%b trig=%b, want 1/0/0/0",
               ClearTrigId, PendCnt, Overflow, TrigOut);
    end
    // ECR held into CLEAR is merged; an LV1 during CLEAR is queued.
    Lv1Cmd = 1'b1;
    tick();
    Lv1Cmd = 1'b0;
    EcrCmd = 1'b0;
    compared++;
    if (ClearTrigId !== 1'b0 || PendCnt !== 3'd1 || FsmState !== 2'd0) begin
      mismatched++;
      $display("FAIL clear_merge: got clr=%b pend=%0d st=%0d, want 0/1/0", ClearTrigId, PendCnt, FsmState);
    end
    tick();
    compared++;
    if (TrigOut !== 1'b1 || BurstIdx !== 4'd0 || PendCnt !== 3'd0) begin
      mismatched++;
      $display("FAIL clear_lv1: got trig=%b idx=%0d pend=%0d, want 1/0/0", TrigOut, BurstIdx, PendCnt);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset && TrigOut === 1'b1 && ClearTrigId === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL exclusive: TrigOut and ClearTrigId both 1, want at most one");
    end
  end

  initial begin
    test_reset();
    test_single_pulse();
    test_burst16();
    test_back_to_back();
    test_overflow();
    test_ecr_abort();
    test_async_reset();
    test_lv1_ecr_same_cycle();
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
